// File: rtl/serial_addsub_ctrl_pkg.sv
// Shared types and constants for the bit-serial add/subtract controller.
// The state encoding is also what the controller drives on its dbg_state port.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // Bit-counter width for a WIDTH-bit operation (never narrower than one bit).
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_addsub_ctrl_full_adder.sv
// Single-bit full-adder slice shared across all bit positions by the controller.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial adder/subtractor: one full-adder slice walked LSB-first over WIDTH cycles.
// Handshakes: a transfer happens on a rising edge where valid && ready are both high.
module serial_addsub_ctrl
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q,     state_d;
  logic [CW-1:0]    cnt_q,       cnt_d;
  logic [WIDTH-1:0] a_q,         a_d;
  logic [WIDTH-1:0] b_q,         b_d;
  logic             carry_q,     carry_d;
  logic [WIDTH-1:0] sum_q,       sum_d;
  logic [WIDTH-1:0] result_q,    result_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q,  overflow_d;

  logic fa_sum;
  logic fa_cout;
  logic accept;

  full_adder u_slice (
    .a    (a_q[cnt_q]),
    .b    (b_q[cnt_q]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      sum_q       <= sum_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    sum_d       = sum_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    accept      = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
      end
      RUN: begin
        busy         = 1'b1;
        sum_d[cnt_q] = fa_sum;
        carry_d      = fa_cout;
        if (cnt_q == LAST_BIT) begin
          // Last slice: its carry-in vs carry-out gives signed overflow.
          state_d               = DONE;
          result_d              = sum_q;
          result_d[WIDTH-1]     = fa_sum;
          carry_out_d           = fa_cout;
          overflow_d            = carry_q ^ fa_cout;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) accept  = 1'b1;
          else          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Subtraction runs as A + ~B + 1: invert B and preload the carry.
    if (accept) begin
      state_d = RUN;
      cnt_d   = '0;
      a_d     = a;
      b_d     = (op == OP_SUB) ? ~b : b;
      carry_d = op;
      sum_d   = '0;
    end
  end

  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Self-checking bench for serial_addsub_ctrl at WIDTH=8.
module tb_serial_addsub_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;
  logic         busy;
  logic [1:0]   dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;

  // {overflow, carry_out, result}
  logic [W+1:0] exp_q[$];

  serial_addsub_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic s);
    logic [W:0]   full;
    logic [W-1:0] r;
    logic         v;
    if (s) full = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
    else   full = {1'b0, x} + {1'b0, y};
    r = full[W-1:0];
    if (s) v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    else   v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    return {v, full[W], r};
  endfunction

  // ---------------- driver tasks ----------------
  // Presents an operand pair, waits (bounded) for the accept edge, pushes the expectation.
  task automatic send_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic top,
                         output bit ok);
    ok       = 1'b0;
    a        = ta;
    b        = tb;
    op       = top;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (ok) exp_q.push_back(model(ta, tb, top));
  endtask

  // Waits up to 20 edges for out_valid; lat=0 on timeout.
  task automatic wait_out(input bit scramble, output int lat, output int busy_n,
                          output int rdy_viol);
    lat      = 0;
    busy_n   = 0;
    rdy_viol = 0;
    for (int i = 1; i <= 20; i++) begin
      if (scramble) begin
        a        = W'($urandom_range(0, 255));
        b        = W'($urandom_range(0, 255));
        op       = 1'($urandom_range(0, 1));
        in_valid = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      if (out_valid) begin
        lat      = i;
        in_valid = 1'b0;
        break;
      end
      if (busy)     busy_n++;
      if (in_ready) rdy_viol++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    op        = 1'b0;
    #3;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    tests_run++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL reset_valid_busy: got %b%b want 00", out_valid, busy);
    end
    tests_run++;
    if ({overflow, carry_out, result} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h want 0", {overflow, carry_out, result});
    end
    tests_run++;
    if (dbg_state !== 2'd0) begin
      tests_failed++; $display("FAIL reset_state: got %0d want 0", dbg_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_arith(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                            input logic top);
    bit ok;
    int lat, busy_n, rdy_viol;
    logic [W+1:0] exp;
    out_ready = 1'b1;
    send_op(ta, tb, top, ok);
    tests_run++;
    if (!ok || in_ready !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_accept: ok=%0d in_ready=%b busy=%b want 1/0/1", name, ok, in_ready, busy);
    end
    wait_out(1'b0, lat, busy_n, rdy_viol);
    tests_run++;
    if (lat !== W || busy_n !== W - 1) begin
      tests_failed++;
      $display("FAIL %s_latency: lat=%0d busy_cycles=%0d want %0d/%0d", name, lat, busy_n, W, W-1);
    end
    if (lat != 0 && exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      tests_run++;
      if ({overflow, carry_out, result} !== exp) begin
        tests_failed++;
        $display("FAIL %s_result: got r=%h c=%b v=%b want r=%h c=%b v=%b", name,
                 result, carry_out, overflow, exp[W-1:0], exp[W], exp[W+1]);
      end
    end
    @(posedge clk); #1;
    tests_run++;
    if (out_valid !== 1'b0 || dbg_state !== 2'd0) begin
      tests_failed++;
      $display("FAIL %s_release: out_valid=%b state=%0d want 0/0", name, out_valid, dbg_state);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int lat, busy_n, rdy_viol;
    logic [W+1:0] exp, snap;
    out_ready = 1'b0;
    send_op(8'hC8, 8'h64, 1'b0, ok);
    wait_out(1'b0, lat, busy_n, rdy_viol);
    tests_run++;
    if (lat !== W || exp_q.size() == 0) begin
      tests_failed++; $display("FAIL bp_latency: got %0d want %0d", lat, W);
    end else begin
      exp = exp_q.pop_front();
      tests_run++;
      if ({overflow, carry_out, result} !== exp) begin
        tests_failed++;
        $display("FAIL bp_result: got %h want %h", {overflow, carry_out, result}, exp);
      end
    end
    snap = {overflow, carry_out, result};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if ({out_valid, in_ready, overflow, carry_out, result} !== {2'b10, snap}) begin
        tests_failed++;
        $display("FAIL bp_hold: cycle %0d got v=%b r=%b %h want v=1 r=0 %h", i,
                 out_valid, in_ready, {overflow, carry_out, result}, snap);
      end
    end
    out_ready = 1'b1;
    send_op(8'h10, 8'h20, 1'b0, ok);
    tests_run++;
    if (!ok || out_valid !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_back_to_back: ok=%0d out_valid=%b busy=%b want 1/0/1", ok, out_valid, busy);
    end
    wait_out(1'b0, lat, busy_n, rdy_viol);
    tests_run++;
    if (lat !== W || exp_q.size() == 0) begin
      tests_failed++; $display("FAIL bp_second_latency: got %0d want %0d", lat, W);
    end else begin
      exp = exp_q.pop_front();
      tests_run++;
      if ({overflow, carry_out, result} !== exp) begin
        tests_failed++;
        $display("FAIL bp_second_result: got %h want %h", {overflow, carry_out, result}, exp);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_operand_stability();
    bit ok;
    int lat, busy_n, rdy_viol;
    logic [W+1:0] exp;
    out_ready = 1'b1;
    send_op(8'h9C, 8'h27, 1'b1, ok);
    wait_out(1'b1, lat, busy_n, rdy_viol);
    tests_run++;
    if (lat !== W || rdy_viol !== 0) begin
      tests_failed++;
      $display("FAIL stab_timing: lat=%0d in_ready_in_run=%0d want %0d/0", lat, rdy_viol, W);
    end
    if (lat != 0 && exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      tests_run++;
      if ({overflow, carry_out, result} !== exp) begin
        tests_failed++;
        $display("FAIL stab_result: got %h want %h", {overflow, carry_out, result}, exp);
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    int seen;
    out_ready = 1'b1;
    send_op(8'hA5, 8'h3C, 1'b0, ok);
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (dbg_state !== 2'd1 || !ok) begin
      tests_failed++; $display("FAIL rst_mid_pre: state=%0d want 1", dbg_state);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({out_valid, busy, in_ready, overflow, carry_out, result, dbg_state} !==
        {3'b001, {(W+2){1'b0}}, 2'd0}) begin
      tests_failed++;
      $display("FAIL rst_mid_async: v=%b busy=%b rdy=%b out=%h state=%0d want 0/0/1/0/0",
               out_valid, busy, in_ready, {overflow, carry_out, result}, dbg_state);
    end
    if (ok) void'(exp_q.pop_back());
    #3 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    tests_run++;
    if (seen !== 0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_mid_after: stale_valid=%0d in_ready=%b want 0/1", seen, in_ready);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_arith("add_35_4a", 8'h35, 8'h4A, 1'b0);
    test_arith("add_ff_01", 8'hFF, 8'h01, 1'b0);
    test_arith("add_7f_01", 8'h7F, 8'h01, 1'b0);
    test_arith("sub_80_01", 8'h80, 8'h01, 1'b1);
    test_arith("sub_05_07", 8'h05, 8'h07, 1'b1);
    for (int i = 0; i < 4; i++) begin
      test_arith("rand", W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)));
    end
    test_backpressure();
    test_operand_stability();
    test_reset_mid_run();
    tests_run++;
    if (exp_q.size() !== 0) begin
      tests_failed++; $display("FAIL scoreboard_drain: %0d entries left want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
